job_scheduler: RTL and testbench

JOB_SCHEDULER -- requirements
Module: job_scheduler

---
 rtl/job_sched_if.sv | 22 ++
 rtl/job_scheduler.sv | 132 +++++++++++++
 tb/tb_job_scheduler.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/job_sched_if.sv
// Handshake bundle for job_scheduler: input word stream in, tagged word stream out.
interface job_sched_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) ();
  logic                    in_valid;
  logic [DATA_W-1:0]       in_data;
  logic                    in_ready;
  logic                    out_valid;
  logic [DATA_W+TAG_W-1:0] out_data;
  logic                    out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/job_scheduler.sv
// Frame-buffering job scheduler: collects a frame into a FIFO, then drains it with routing tags.
// Optional round-robin destination tagging is enabled by defining JOB_SCHED_RR_EN.
module job_scheduler #(
  parameter int              DATA_W    = 32,
  parameter int              DEPTH     = 1024,
  parameter int              TAG_W     = 4,
  parameter int              NUM_DEST  = 4,
  parameter int              DEST_BASE = 1,
  parameter logic [DATA_W-1:0] END_WORD = '1,
  localparam int             LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  job_sched_if.slave       bus,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             frame_done,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              accept;
  logic              is_end;
  logic              wr_en;
  logic              pop;
  logic              last_pop;
  logic [TAG_W-1:0]  tag;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  always_comb begin
    bus.in_ready = 1'b0;
    if (reset) begin
      case (state)
        IDLE:    bus.in_ready = 1'b1;
        LOAD:    bus.in_ready = !full;
        default: bus.in_ready = 1'b0;
      endcase
    end
  end

  assign bus.out_valid = reset && (state == DRAIN) && !empty;
  assign accept        = bus.in_valid && bus.in_ready;
  assign is_end        = (bus.in_data == END_WORD);
  assign wr_en         = accept && !is_end;
  assign pop           = bus.out_valid && bus.out_ready;
  assign last_pop      = pop && (level == LVL_W'(1));

  // Payload is read straight from storage so the head word is presented with no extra latency;
  // gating on out_valid keeps stale storage invisible while empty.
  assign bus.out_data  = bus.out_valid ? {mem[rd_ptr], tag} : '0;

`ifdef JOB_SCHED_RR_EN
  localparam int IDX_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
  logic [IDX_W-1:0] idx;

  // Rotation restarts at destination 0 for every frame, so the index is cleared on the frame's final pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (pop) begin
      if (last_pop || (idx == IDX_W'(NUM_DEST - 1))) idx <= '0;
      else                                          idx <= idx + 1'b1;
    end
  end

  assign tag = TAG_W'(DEST_BASE) + TAG_W'(idx);
`else
  assign tag = TAG_W'(DEST_BASE);
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.in_data;
  end

  // Load and drain phases are exclusive, so level never sees a write and a pop on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      ovf        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        level  <= level + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        level  <= level - 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            ovf <= 1'b0;
            if (!is_end) state <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            if (is_end) begin
              state <= DRAIN;
            end else if (level == LVL_W'(DEPTH - 1)) begin
              ovf   <= 1'b1;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (last_pop) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_job_scheduler.sv
// Bench for job_scheduler: a default-size instance and a DEPTH=4 instance share one driver.
module tb_job_scheduler;

  localparam logic [31:0] END_W = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        iv = 1'b0;
  logic        ordy = 1'b0;
  logic [31:0] id = '0;

  int checks = 0;
  int passed = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  job_sched_if #(.DATA_W(32), .TAG_W(4)) bif ();
  job_sched_if #(.DATA_W(32), .TAG_W(4)) sif ();

  assign bif.in_valid  = iv & ~sel;
  assign bif.in_data   = id;
  assign bif.out_ready = ordy & ~sel;
  assign sif.in_valid  = iv & sel;
  assign sif.in_data   = id;
  assign sif.out_ready = ordy & sel;

  logic        full_b, empty_b, fd_b, ovf_b;
  logic [10:0] level_b;
  logic        full_s, empty_s, fd_s, ovf_s;
  logic [2:0]  level_s;

  job_scheduler u_big (
    .clk(clk), .reset(rst_n), .bus(bif),
    .full(full_b), .empty(empty_b), .level(level_b), .frame_done(fd_b), .ovf(ovf_b)
  );

  job_scheduler #(.DEPTH(4)) u_small (
    .clk(clk), .reset(rst_n), .bus(sif),
    .full(full_s), .empty(empty_s), .level(level_s), .frame_done(fd_s), .ovf(ovf_s)
  );

  wire        ir  = sel ? sif.in_ready  : bif.in_ready;
  wire        ov  = sel ? sif.out_valid : bif.out_valid;
  wire [35:0] od  = sel ? sif.out_data  : bif.out_data;
  wire        fl  = sel ? full_s  : full_b;
  wire        em  = sel ? empty_s : empty_b;
  wire        fd  = sel ? fd_s    : fd_b;
  wire        ovf = sel ? ovf_s   : ovf_b;
  wire [10:0] lvl = sel ? {8'd0, level_s} : level_b;

  // Expected routing tag of the k-th word popped in a frame.
  function automatic logic [3:0] exp_tag(input int k);
`ifdef JOB_SCHED_RR_EN
    return 4'(1 + (k % 4));
`else
    return 4'd1;
`endif
  endfunction

  task automatic send(input logic [31:0] d, output bit acc);
    @(negedge clk);
    iv = 1'b1;
    id = d;
    #1;
    acc = ir;
    if (acc && d != END_W) q.push_back(d);
    @(posedge clk);
    #1;
    iv = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit with_end);
    bit acc;
    for (int i = 0; i < n; i++) begin
      send($urandom & 32'h7FFF_FFFF, acc);
      checks++;
      if (acc !== 1'b1) $display("FAIL accept_word%0d: in_ready=%b required 1", i, acc);
      else passed++;
    end
    if (with_end) begin
      send(END_W, acc);
      checks++;
      if (acc !== 1'b1) $display("FAIL accept_end: in_ready=%b required 1", acc);
      else passed++;
    end
  endtask

  task automatic drain(input int n, input bit rnd);
    int got = 0;
    int cyc = 0;
    bit popped;
    bit hold_v = 1'b0;
    logic [35:0] held;
    logic [35:0] e;
    while (got < n && cyc < n * 20 + 20) begin
      @(negedge clk);
      ordy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      popped = 1'b0;
      if (hold_v) begin
        checks++;
        if (od !== held || ov !== 1'b1) $display("FAIL hold_stable: out_data=%h valid=%b required %h valid=1", od, ov, held);
        else passed++;
      end
      if (ov) begin
        if (ordy) begin
          e = {(q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF, exp_tag(got)};
          checks++;
          if (od !== e) $display("FAIL out_word%0d: out_data=%h required %h", got, od, e);
          else passed++;
          got++;
          popped = 1'b1;
          hold_v = 1'b0;
        end else begin
          held = od;
          hold_v = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      checks++;
      if (fd !== (popped && got == n)) $display("FAIL frame_done: frame_done=%b required %b", fd, popped && got == n);
      else passed++;
      cyc++;
    end
    ordy = 1'b0;
    checks++;
    if (got != n) $display("FAIL drain_count: popped %0d words required %0d", got, n);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (fd !== 1'b0 || em !== 1'b1 || ov !== 1'b0 || ir !== 1'b1)
      $display("FAIL post_drain: fd=%b empty=%b valid=%b in_ready=%b required 0 1 0 1", fd, em, ov, ir);
    else passed++;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (ir !== 1'b0 || ov !== 1'b0 || od !== '0 || lvl !== '0 || fd !== 1'b0 || ovf !== 1'b0)
      $display("FAIL reset_state: ir=%b ov=%b od=%h lvl=%0d fd=%b ovf=%b required all zero", ir, ov, od, lvl, fd, ovf);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ir !== 1'b1 || em !== 1'b1) $display("FAIL idle_after_reset: in_ready=%b empty=%b required 1 1", ir, em);
    else passed++;
  endtask

  task automatic test_rr_frame;
    bit acc;
    for (int i = 0; i < 5; i++) begin
      send(32'h10 + 32'(i), acc);
      checks++;
      if (acc !== 1'b1) $display("FAIL rr_accept%0d: in_ready=%b required 1", i, acc);
      else passed++;
    end
    send(END_W, acc);
    checks++;
    if (lvl !== 11'd5 || ir !== 1'b0) $display("FAIL rr_level: level=%0d in_ready=%b required 5 0", lvl, ir);
    else passed++;
    drain(5, 1'b0);
  endtask

  task automatic test_random_frames;
    int n;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 20);
      send_frame(n, 1'b1);
      checks++;
      if (lvl !== 11'(q.size())) $display("FAIL rand_level: level=%0d required %0d", lvl, q.size());
      else passed++;
      drain(n, 1'b1);
    end
  endtask

  task automatic test_stall;
    logic [35:0] h;
    logic [10:0] l;
    send_frame(3, 1'b1);
    @(negedge clk);
    #1;
    h = od;
    l = lvl;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (od !== h || lvl !== l || ov !== 1'b1 || l !== 11'd3)
        $display("FAIL stall_hold: od=%h lvl=%0d ov=%b required %h 3 1", od, lvl, ov, h);
      else passed++;
    end
    drain(3, 1'b0);
  endtask

  task automatic test_end_only;
    bit acc;
    send(END_W, acc);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (acc !== 1'b1 || ov !== 1'b0 || lvl !== '0 || fd !== 1'b0 || ir !== 1'b1)
        $display("FAIL end_only: acc=%b ov=%b lvl=%0d fd=%b ir=%b required 1 0 0 0 1", acc, ov, lvl, fd, ir);
      else passed++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_depth4;
    bit acc;
    sel = 1'b1;
    send_frame(3, 1'b1);
    checks++;
    if (ovf !== 1'b0 || lvl !== 11'd3 || ir !== 1'b0) $display("FAIL d4_fit: ovf=%b lvl=%0d ir=%b required 0 3 0", ovf, lvl, ir);
    else passed++;
    drain(3, 1'b1);
    send_frame(4, 1'b0);
    checks++;
    if (ovf !== 1'b1 || fl !== 1'b1 || ir !== 1'b0 || ov !== 1'b1)
      $display("FAIL d4_overflow: ovf=%b full=%b ir=%b ov=%b required 1 1 0 1", ovf, fl, ir, ov);
    else passed++;
    send(32'h1234, acc);
    checks++;
    if (acc !== 1'b0) $display("FAIL d4_reject: in_ready=%b required 0", acc);
    else passed++;
    drain(4, 1'b1);
    checks++;
    if (ovf !== 1'b1) $display("FAIL d4_sticky: ovf=%b required 1", ovf);
    else passed++;
    send_frame(1, 1'b1);
    checks++;
    if (ovf !== 1'b0) $display("FAIL d4_ovf_clear: ovf=%b required 0", ovf);
    else passed++;
    drain(1, 1'b0);
    sel = 1'b0;
  endtask

  task automatic test_reset_drain;
    send_frame(2, 1'b1);
    @(negedge clk);
    checks++;
    if (lvl !== 11'd2 || ov !== 1'b1) $display("FAIL rd_pre: lvl=%0d ov=%b required 2 1", lvl, ov);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov !== 1'b0 || lvl !== '0 || ir !== 1'b0 || fd !== 1'b0)
      $display("FAIL rd_async: ov=%b lvl=%0d ir=%b fd=%b required 0 0 0 0", ov, lvl, ir, fd);
    else passed++;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (fd !== 1'b0 || ir !== 1'b1 || em !== 1'b1) $display("FAIL rd_idle: fd=%b ir=%b em=%b required 0 1 1", fd, ir, em);
    else passed++;
    send_frame(3, 1'b1);
    drain(3, 1'b0);
  endtask

  initial begin
    test_reset();
    test_rr_frame();
    test_end_only();
    test_stall();
    test_random_frames();
    test_depth4();
    test_reset_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
